// File: rtl/braille_decoder_if.sv
// Cell-stream handshake and message-memory write port of the Braille decoder.
// "master" is the environment side (cell source plus RAM write port),
// "slave" is the decoder itself.
interface braille_decoder_if;
    logic [5:0] cell_in;
    logic       cell_valid;
    logic       cell_last;
    logic       cell_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;

    modport master (
        output cell_in,
        output cell_valid,
        output cell_last,
        input  cell_ready,
        input  mem_addr,
        input  mem_din,
        input  mem_we
    );

    modport slave (
        input  cell_in,
        input  cell_valid,
        input  cell_last,
        output cell_ready,
        output mem_addr,
        output mem_din,
        output mem_we
    );
endinterface

// File: rtl/braille_decoder.sv
// Braille-to-ASCII decoder: resolves capital/number indicators, writes the
// decoded characters to addresses 1..N of the message RAM and the character
// count to address 0, then holds done until reset.
module braille_decoder #(
    parameter int unsigned MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              reset,
    braille_decoder_if.slave  bus,
    output logic              done,
    output logic              bad_cell
);

    localparam logic [1:0] RECV = 2'd0;
    localparam logic [1:0] LEN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] CAP_IND  = 6'h01;
    localparam logic [5:0] NUM_IND  = 6'h17;
    localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);
    localparam logic [7:0] UNKNOWN  = 8'h3F;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       cap_pend;
    logic       num_pend;

    logic       accept;
    logic       is_ind;
    logic       letter_hit;
    logic [7:0] letter_code;
    logic       punct_hit;
    logic [7:0] punct_code;
    logic       digit_hit;
    logic [7:0] digit_code;
    logic [7:0] dec_byte;
    logic       dec_bad;

    assign accept = bus.cell_ready && bus.cell_valid;
    assign is_ind = (bus.cell_in == CAP_IND) || (bus.cell_in == NUM_IND);

    // Lowercase letter lookup; 0x1A is always 's'.
    always_comb begin
        letter_hit  = 1'b1;
        letter_code = 8'h00;
        case (bus.cell_in)
            6'h20: letter_code = 8'h61;
            6'h28: letter_code = 8'h62;
            6'h30: letter_code = 8'h63;
            6'h34: letter_code = 8'h64;
            6'h24: letter_code = 8'h65;
            6'h38: letter_code = 8'h66;
            6'h3C: letter_code = 8'h67;
            6'h2C: letter_code = 8'h68;
            6'h18: letter_code = 8'h69;
            6'h1C: letter_code = 8'h6A;
            6'h22: letter_code = 8'h6B;
            6'h2A: letter_code = 8'h6C;
            6'h32: letter_code = 8'h6D;
            6'h36: letter_code = 8'h6E;
            6'h26: letter_code = 8'h6F;
            6'h3A: letter_code = 8'h70;
            6'h3E: letter_code = 8'h71;
            6'h2E: letter_code = 8'h72;
            6'h1A: letter_code = 8'h73;
            6'h1E: letter_code = 8'h74;
            6'h23: letter_code = 8'h75;
            6'h2B: letter_code = 8'h76;
            6'h1D: letter_code = 8'h77;
            6'h33: letter_code = 8'h78;
            6'h37: letter_code = 8'h79;
            6'h27: letter_code = 8'h7A;
            default: letter_hit = 1'b0;
        endcase
    end

    // Punctuation and space lookup.
    always_comb begin
        punct_hit  = 1'b1;
        punct_code = 8'h00;
        case (bus.cell_in)
            6'h00: punct_code = 8'h20;
            6'h0E: punct_code = 8'h21;
            6'h0A: punct_code = 8'h22;
            6'h39: punct_code = 8'h24;
            6'h35: punct_code = 8'h25;
            6'h2D: punct_code = 8'h26;
            6'h08: punct_code = 8'h27;
            6'h1B: punct_code = 8'h28;
            6'h1F: punct_code = 8'h29;
            6'h25: punct_code = 8'h2A;
            6'h16: punct_code = 8'h2B;
            6'h02: punct_code = 8'h2C;
            6'h09: punct_code = 8'h2D;
            6'h03: punct_code = 8'h2E;
            6'h13: punct_code = 8'h2F;
            6'h12: punct_code = 8'h3A;
            6'h11: punct_code = 8'h3C;
            default: punct_hit = 1'b0;
        endcase
    end

    // Digit lookup used only after a number indicator: a..i -> 1..9, 0x0F -> 0.
    always_comb begin
        digit_hit  = 1'b1;
        digit_code = 8'h00;
        case (bus.cell_in)
            6'h20: digit_code = 8'h31;
            6'h28: digit_code = 8'h32;
            6'h30: digit_code = 8'h33;
            6'h34: digit_code = 8'h34;
            6'h24: digit_code = 8'h35;
            6'h38: digit_code = 8'h36;
            6'h3C: digit_code = 8'h37;
            6'h2C: digit_code = 8'h38;
            6'h18: digit_code = 8'h39;
            6'h0F: digit_code = 8'h30;
            default: digit_hit = 1'b0;
        endcase
    end

    // Final character selection; a pending flag that cannot apply is an error
    // and the cell falls back to its plain meaning.
    always_comb begin
        dec_byte = UNKNOWN;
        dec_bad  = 1'b0;
        if (cap_pend && letter_hit) begin
            dec_byte = letter_code - 8'h20;
        end else if (num_pend && digit_hit) begin
            dec_byte = digit_code;
        end else begin
            dec_bad = cap_pend || num_pend;
            if (letter_hit) begin
                dec_byte = letter_code;
            end else if (punct_hit) begin
                dec_byte = punct_code;
            end else begin
                dec_byte = UNKNOWN;
                dec_bad  = 1'b1;
            end
        end
    end

    // Control FSM, character counter and registered memory/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RECV;
            cnt            <= '0;
            cap_pend       <= 1'b0;
            num_pend       <= 1'b0;
            bus.cell_ready <= 1'b1;
            bus.mem_addr   <= '0;
            bus.mem_din    <= '0;
            bus.mem_we     <= 1'b0;
            done           <= 1'b0;
            bad_cell       <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                RECV: begin
                    if (accept) begin
                        if (is_ind) begin
                            cap_pend <= (bus.cell_in == CAP_IND);
                            num_pend <= (bus.cell_in == NUM_IND);
                            if (cap_pend || num_pend) begin
                                bad_cell <= 1'b1;
                            end
                            // A trailing indicator has no character of its own,
                            // so the count write is issued straight away.
                            if (bus.cell_last) begin
                                bad_cell       <= 1'b1;
                                bus.cell_ready <= 1'b0;
                                bus.mem_we     <= 1'b1;
                                bus.mem_addr   <= '0;
                                bus.mem_din    <= cnt;
                                state          <= DONE;
                            end
                        end else begin
                            cap_pend     <= 1'b0;
                            num_pend     <= 1'b0;
                            bus.mem_we   <= 1'b1;
                            bus.mem_addr <= cnt + 8'd1;
                            bus.mem_din  <= dec_byte;
                            cnt          <= cnt + 8'd1;
                            if (dec_bad) begin
                                bad_cell <= 1'b1;
                            end
                            if (bus.cell_last || (cnt == LAST_CNT)) begin
                                bus.cell_ready <= 1'b0;
                                state          <= LEN;
                                if (!bus.cell_last) begin
                                    bad_cell <= 1'b1;
                                end
                            end
                        end
                    end
                end
                LEN: begin
                    bus.mem_we   <= 1'b1;
                    bus.mem_addr <= '0;
                    bus.mem_din  <= cnt;
                    state        <= DONE;
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_braille_decoder.sv
// Self-checking bench for braille_decoder: two instances (MAX_LEN 255 and 4)
// share one cell stream; a table-driven model predicts memory contents,
// count, error flag and write/done timing.
module tb_braille_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #50 clk = ~clk;

    braille_decoder_if bus_a ();
    braille_decoder_if bus_b ();
    logic done_a, done_b, bad_a, bad_b;

    braille_decoder #(.MAX_LEN(255)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .done(done_a), .bad_cell(bad_a)
    );
    braille_decoder #(.MAX_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .done(done_b), .bad_cell(bad_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic       we_s   [2];
    logic       dn_s   [2];
    logic       bad_s  [2];
    logic       rdy_s  [2];
    logic [7:0] addr_s [2];
    logic [7:0] din_s  [2];
    assign we_s[0] = bus_a.mem_we;      assign we_s[1] = bus_b.mem_we;
    assign dn_s[0] = done_a;            assign dn_s[1] = done_b;
    assign bad_s[0] = bad_a;            assign bad_s[1] = bad_b;
    assign rdy_s[0] = bus_a.cell_ready; assign rdy_s[1] = bus_b.cell_ready;
    assign addr_s[0] = bus_a.mem_addr;  assign addr_s[1] = bus_b.mem_addr;
    assign din_s[0] = bus_a.mem_din;    assign din_s[1] = bus_b.mem_din;

    logic [7:0] mem      [2][256];
    int         wcyc     [2][256];
    int         nwr      [2];
    int         cw_cyc   [2];
    int         done_cyc [2];

    logic [5:0] let_tab [26] = '{6'h20, 6'h28, 6'h30, 6'h34, 6'h24, 6'h38, 6'h3C, 6'h2C, 6'h18,
                                 6'h1C, 6'h22, 6'h2A, 6'h32, 6'h36, 6'h26, 6'h3A, 6'h3E, 6'h2E,
                                 6'h1A, 6'h1E, 6'h23, 6'h2B, 6'h1D, 6'h33, 6'h37, 6'h27};
    logic [5:0] pun_cell [17] = '{6'h00, 6'h0E, 6'h0A, 6'h39, 6'h35, 6'h2D, 6'h08, 6'h1B, 6'h1F,
                                  6'h25, 6'h16, 6'h02, 6'h09, 6'h03, 6'h13, 6'h12, 6'h11};
    logic [7:0] pun_chr [17] = '{8'h20, 8'h21, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29,
                                 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h3A, 8'h3C};

    logic [5:0] cells [$];
    int         acc_edge [$];

    logic [7:0] m_q [$];
    int         m_idx [$];
    bit         m_bad, m_ended, m_ind;
    int         m_last;

    // Cycle counter: value k holds between edge k and edge k+1.
    always @(posedge clk) cyc = cyc + 1;

    // Memory image and event-time capture for both instances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                nwr[d] = 0;
                cw_cyc[d] = -1;
                done_cyc[d] = -1;
                for (int k = 0; k < 256; k++) begin
                    mem[d][k] = 8'hEE;
                    wcyc[d][k] = -1;
                end
            end else begin
                if (we_s[d]) begin
                    mem[d][addr_s[d]] = din_s[d];
                    wcyc[d][addr_s[d]] = cyc;
                    nwr[d] = nwr[d] + 1;
                    if (addr_s[d] == 8'h00) cw_cyc[d] = cyc;
                end
                if (dn_s[d] && done_cyc[d] < 0) done_cyc[d] = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] c, input logic v, input logic l);
        bus_a.cell_in = c;  bus_a.cell_valid = v;  bus_a.cell_last = l;
        bus_b.cell_in = c;  bus_b.cell_valid = v;  bus_b.cell_last = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(6'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send(input bit last_final, input bit gaps);
        acc_edge.delete();
        for (int i = 0; i < cells.size(); i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive(6'($urandom), 1'b0, 1'($urandom));
                @(negedge clk);
            end
            chk("ready_a_during_msg", {31'd0, rdy_s[0]}, 32'd1);
            drive(cells[i], 1'b1, last_final && (i == cells.size() - 1));
            acc_edge.push_back(cyc + 1);
        end
        @(negedge clk);
        drive(6'($urandom), 1'b0, 1'b0);
    endtask

    // Decoding rules applied cell by cell over lookup tables.
    task automatic model(input int maxlen, input bit last_final);
        bit cap, num, fin;
        int li, pi;
        logic [7:0] ch;
        logic [5:0] c;
        cap = 0; num = 0;
        m_q.delete(); m_idx.delete();
        m_bad = 0; m_ended = 0; m_ind = 0; m_last = -1;
        for (int i = 0; i < cells.size(); i++) begin
            c = cells[i];
            fin = last_final && (i == cells.size() - 1);
            if (c == 6'h01 || c == 6'h17) begin
                if (cap || num) m_bad = 1;
                cap = (c == 6'h01);
                num = (c == 6'h17);
                if (fin) begin
                    m_bad = 1; m_ended = 1; m_ind = 1; m_last = i;
                    break;
                end
                continue;
            end
            li = -1; pi = -1;
            for (int k = 0; k < 26; k++) if (let_tab[k] == c) li = k;
            for (int k = 0; k < 17; k++) if (pun_cell[k] == c) pi = k;
            if (cap && li >= 0)                 ch = 8'(65 + li);
            else if (num && li >= 0 && li < 9)  ch = 8'(49 + li);
            else if (num && c == 6'h0F)         ch = 8'h30;
            else begin
                if (cap || num) m_bad = 1;
                if (li >= 0)      ch = 8'(97 + li);
                else if (pi >= 0) ch = pun_chr[pi];
                else begin
                    ch = 8'h3F;
                    m_bad = 1;
                end
            end
            cap = 0; num = 0;
            m_q.push_back(ch);
            m_idx.push_back(i);
            if (fin || m_q.size() == maxlen) begin
                if (!fin) m_bad = 1;
                m_ended = 1; m_last = i;
                break;
            end
        end
    endtask

    task automatic check_dut(input int d, input string tag, input int maxlen, input bit last_final);
        int n, last_e;
        model(maxlen, last_final);
        for (int t = 0; t < 40 && !dn_s[d]; t++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk({tag, "_done"}, {31'd0, dn_s[d]}, 32'd1);
        chk({tag, "_ended"}, {31'd0, m_ended}, 32'd1);
        if (!m_ended) return;
        n = m_q.size();
        last_e = acc_edge[m_last];
        chk({tag, "_nwrites"}, nwr[d], n + 1);
        chk({tag, "_count"}, {24'd0, mem[d][0]}, n);
        chk({tag, "_bad"}, {31'd0, bad_s[d]}, {31'd0, m_bad});
        chk({tag, "_ready"}, {31'd0, rdy_s[d]}, 32'd0);
        chk({tag, "_cw_delay"}, cw_cyc[d] - last_e, m_ind ? 0 : 1);
        chk({tag, "_done_delay"}, done_cyc[d] - last_e, m_ind ? 1 : 2);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_char"}, {24'd0, mem[d][k + 1]}, {24'd0, m_q[k]});
            chk({tag, "_char_delay"}, wcyc[d][k + 1] - acc_edge[m_idx[k]], 0);
        end
    endtask

    task automatic check_reset_vals(input int d, input string tag);
        chk({tag, "_ready"}, {31'd0, rdy_s[d]}, 32'd1);
        chk({tag, "_addr"}, {24'd0, addr_s[d]}, 32'd0);
        chk({tag, "_din"}, {24'd0, din_s[d]}, 32'd0);
        chk({tag, "_we"}, {31'd0, we_s[d]}, 32'd0);
        chk({tag, "_done"}, {31'd0, dn_s[d]}, 32'd0);
        chk({tag, "_bad"}, {31'd0, bad_s[d]}, 32'd0);
    endtask

    initial begin
        int len, sel;
        drive(6'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals(0, "rst_a");
        check_reset_vals(1, "rst_b");
        reset = 1'b1;

        // Capital indicator: "Hi"
        cells = '{6'h01, 6'h2C, 6'h18};
        send(1, 0);
        check_dut(0, "hi_a", 255, 1);
        check_dut(1, "hi_b", 4, 1);
        chk("hi_m1", {24'd0, mem[0][1]}, 32'h48);
        chk("hi_m2", {24'd0, mem[0][2]}, 32'h69);
        chk("hi_bad", {31'd0, bad_a}, 32'd0);
        do_reset();

        // Number indicator, space, 0x1A as 's'
        cells = '{6'h17, 6'h34, 6'h17, 6'h0F, 6'h00, 6'h1A};
        send(1, 0);
        check_dut(0, "num_a", 255, 1);
        check_dut(1, "num_b", 4, 1);
        chk("num_m1", {24'd0, mem[0][1]}, 32'h34);
        chk("num_m2", {24'd0, mem[0][2]}, 32'h30);
        chk("num_m3", {24'd0, mem[0][3]}, 32'h20);
        chk("num_m4", {24'd0, mem[0][4]}, 32'h73);
        chk("num_m0", {24'd0, mem[0][0]}, 32'd4);
        do_reset();

        // Unmapped cell and capital before punctuation
        cells = '{6'h3B, 6'h01, 6'h03};
        send(1, 0);
        check_dut(0, "unm_a", 255, 1);
        check_dut(1, "unm_b", 4, 1);
        chk("unm_m1", {24'd0, mem[0][1]}, 32'h3F);
        chk("unm_m2", {24'd0, mem[0][2]}, 32'h2E);
        chk("unm_bad", {31'd0, bad_a}, 32'd1);
        do_reset();

        // Overflow on the MAX_LEN=4 instance, no cell_last
        cells = '{6'h20, 6'h28, 6'h30, 6'h34, 6'h24, 6'h38};
        send(0, 0);
        check_dut(1, "ovf_b", 4, 0);
        chk("ovf_b_m0", {24'd0, mem[1][0]}, 32'd4);
        chk("ovf_b_bad", {31'd0, bad_b}, 32'd1);
        chk("ovf_a_nwrites", nwr[0], 6);
        chk("ovf_a_done", {31'd0, done_a}, 32'd0);
        chk("ovf_a_ready", {31'd0, bus_a.cell_ready}, 32'd1);
        do_reset();

        // Trailing indicator
        cells = '{6'h20, 6'h17};
        send(1, 0);
        check_dut(0, "tind_a", 255, 1);
        check_dut(1, "tind_b", 4, 1);
        chk("tind_m1", {24'd0, mem[0][1]}, 32'h61);
        chk("tind_m0", {24'd0, mem[0][0]}, 32'd1);
        chk("tind_bad", {31'd0, bad_a}, 32'd1);
        do_reset();

        // Reset in the middle of a message
        cells = '{6'h20, 6'h28};
        send(0, 0);
        #10;
        reset = 1'b0;
        #1;
        check_reset_vals(0, "midrst_a");
        check_reset_vals(1, "midrst_b");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cells = '{6'h28};
        send(1, 0);
        check_dut(0, "post_a", 255, 1);
        check_dut(1, "post_b", 4, 1);
        chk("post_m1", {24'd0, mem[0][1]}, 32'h62);
        do_reset();

        // Random messages
        for (int m = 0; m < 40; m++) begin
            cells.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < 4)       cells.push_back(let_tab[$urandom_range(0, 25)]);
                else if (sel < 6)  cells.push_back(pun_cell[$urandom_range(0, 16)]);
                else if (sel == 6) cells.push_back(6'h01);
                else if (sel == 7) cells.push_back(6'h17);
                else if (sel == 8) cells.push_back(6'h0F);
                else               cells.push_back(6'($urandom));
            end
            send(1, 1'($urandom));
            check_dut(0, "rnd_a", 255, 1);
            check_dut(1, "rnd_b", 4, 1);
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/braille_decoder.md
# braille_decoder

Reverse-direction companion to the ASCII-to-Braille converter: accepts a stream of 6-bit Braille cells, resolves capital and number indicators, and writes the decoded ASCII text into the same byte-wide message memory layout the converter reads. Address 0 holds the character count and addresses 1..N hold the characters. It sits between a Braille cell source (keypad or cell-entry logic) and the message RAM write port.

## Interface
- MAX_LEN, 255: maximum stored characters (1..255); the message occupies addresses 1..MAX_LEN.
- clk  in  1  system clock, 10 kHz
- reset  in  1  asynchronous, active-low reset
- cell_in  in  6  Braille cell, bit5 = dot1 … bit0 = dot6, same encoding the converter emits
- cell_valid  in  1  cell_in valid this cycle
- cell_last  in  1  qualifies cell_in as the final cell of the message
- cell_ready  out  1  decoder can accept a cell this cycle
- mem_addr  out  8  memory write address
- mem_din  out  8  memory write data
- mem_we  out  1  memory write enable, one cycle per write
- done  out  1  message and count fully written; sticky until reset
- bad_cell  out  1  sticky error flag, see boundary rules

## Operation
- FSM states: RECV (cell_ready=1), LEN (writes the count), DONE (done=1, cell_ready=0, waits for reset).
- A cell is accepted when cell_valid and cell_ready are both high. Cells are ignored in LEN and DONE.
- Indicator cells produce no memory write:
  - 0x01 sets cap_pend.
  - 0x17 sets num_pend.
- Cells with no pending flag:
  - Letters a–z map from 20,28,30,34,24,38,3C,2C,18,1C,22,2A,32,36,26,3A,3E,2E,1A,1E,23,2B,1D,33,37,27 (hex, in alphabet order) to ASCII 0x61–0x7A.
  - Punctuation: 00 ' ', 0E '!', 0A '"', 39 '$', 35 '%', 2D '&', 08 ''', 1B '(', 1F ')', 25 '*', 16 '+', 02 ',', 09 '-', 03 '.', 13 '/', 12 ':', 11 '<'.
  - 0x1A decodes as 's', never ';'.
- cap_pend followed by a letter cell writes the uppercase letter (letter code − 0x20).
- num_pend followed by a cell in a..i writes '1'..'9'; 0x0F writes '0'.
- Every data cell clears both pending flags.
- Character counter cnt[7:0] starts at 0. A data write goes to address cnt+1 with mem_din = decoded byte, then cnt increments.
- Boundary rules (each one sets bad_cell):
  - Unmapped cell with no pending flag writes '?' (0x3F).
  - cap_pend followed by a non-letter, or num_pend followed by a non-digit: decode the cell as if no flag were pending.
  - Indicator followed by another indicator: the new flag replaces the old one.
  - cell_last on an indicator cell: nothing is written for it; go to LEN.
  - Data cell accepted while cnt == MAX_LEN−1: write it, then go to LEN regardless of cell_last. If cell_last was not set on that cell, set bad_cell.
- LEN state: one write with mem_addr=0 and mem_din=cnt, then go to DONE.
- Reset at any time: return to RECV, clear cnt and both pending flags, and drive all outputs to their reset values. Any partially written message is abandoned.

## Timing
- Reset values: cell_ready=1, mem_addr=0, mem_din=0, mem_we=0, done=0, bad_cell=0.
- All outputs are registered.
- Cell accepted on edge N: mem_we, mem_addr and mem_din for that character are valid during cycle N+1.
- Throughput is one cell per cycle, back-to-back.
- Final cell accepted on edge N:
  - cell_ready=0 from cycle N+1.
  - Count write (addr 0) occurs in cycle N+2, or in cycle N+1 if the final cell was an indicator.
  - done=1 from the following cycle.
- mem_we is low in every cycle that has no write.
- bad_cell rises in the same cycle as the offending cell's write, or in the cycle after acceptance for indicator cases.

## Test plan
- Cells 01,2C,18(last) → mem[1]=0x48, mem[2]=0x69, mem[0]=0x02; done rises 3 cycles after the last accept; bad_cell=0.
- Cells 17,34,17,0F,00,1A(last) → mem[1..4] = '4','0',' ','s'; mem[0]=4.
- Cells 3B, 01,03(last) → mem[1]='?', mem[2]='.'; mem[0]=2; bad_cell=1.
- MAX_LEN=4, six back-to-back letter cells with no last → mem[1..4] written; cell_ready=0 after the 4th accept; cells 5–6 ignored; mem[0]=4; bad_cell=1.
- Cells 20,17(last) → mem[1]='a', mem[0]=1; count write 1 cycle after the last accept; bad_cell=1.
- Reset asserted after 2 cells of a message → outputs return to reset values immediately; new message 28(last) → mem[1]='b', mem[0]=1.
